// File: rtl/retire_monitor.sv
// retire_monitor: watches the writeback-stage retire stream of a small core
// and reports whether the program reached END_PC (done) or stalled for
// WDT_CYCLES run cycles without a retire (timeout). It keeps saturating
// cycle and retire counters, the last retired PC, and, when the
// RETIRE_TRACE_EN macro is defined, an 8-entry history of retired PCs.
// Without RETIRE_TRACE_EN there is no trace storage and trace_pc reads 0.
module retire_monitor #(
  parameter int unsigned          ADDR_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0] END_PC     = 32'h0000_0078,
  parameter int unsigned          WDT_CYCLES = 1024,
  parameter int unsigned          CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_SIZE-1:0] pc_w,
  input  logic                 retire_w,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [ADDR_SIZE-1:0] last_pc,
  input  logic [2:0]           trace_idx,
  output logic [ADDR_SIZE-1:0] trace_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  // Watchdog only needs to count up to WDT_CYCLES-1.
  localparam int unsigned      WDT_W    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  state_t           state;
  logic [WDT_W-1:0] wdt;
  logic             is_end;

  assign is_end = (pc_w == END_PC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Run-state FSM with registered status flags, counters and last PC.
  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which keeps the flags consistent with the state they were computed from.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      last_pc    <= '0;
      wdt        <= '0;
    end else if (clear) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      last_pc    <= '0;
      wdt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (retire_w) begin
            retire_cnt <= sat_inc(retire_cnt);
            last_pc    <= pc_w;
            cycle_cnt  <= CNT_W'(1);
            wdt        <= '0;
            if (is_end) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (retire_w) begin
            retire_cnt <= sat_inc(retire_cnt);
            last_pc    <= pc_w;
            wdt        <= '0;
            // An END_PC retire wins over a watchdog expiry in the same cycle.
            if (is_end) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (wdt == WDT_LAST) begin
            state   <= S_TIMEOUT;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wdt <= wdt + 1'b1;
          end
        end
        // DONE and TIMEOUT are sticky; only clear or reset leaves them.
        default: begin
        end
      endcase
    end
  end

`ifdef RETIRE_TRACE_EN
  logic [ADDR_SIZE-1:0] trace_mem [8];
  logic [2:0]           wptr;
  logic                 trace_we;

  // Only retires that are actually counted enter the history.
  assign trace_we = retire_w && !clear && (state == S_IDLE || state == S_RUN);

  // Ring buffer of retired PCs; the 3-bit pointer wraps naturally from 7 to 0.
  // NOTE: the entries are reset because never-written slots must read as 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      for (int i = 0; i < 8; i++) trace_mem[i] <= '0;
    end else if (clear) begin
      wptr <= '0;
      for (int i = 0; i < 8; i++) trace_mem[i] <= '0;
    end else if (trace_we) begin
      trace_mem[wptr] <= pc_w;
      wptr            <= wptr + 3'd1;
    end
  end

  // Index 0 is the newest entry; 3-bit arithmetic gives the mod-8 wrap.
  assign trace_pc = trace_mem[wptr - 3'd1 - trace_idx];
`else
  logic unused_trace_idx;

  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: directed bench for retire_monitor built with
// WDT_CYCLES=16. A table of single-cycle vectors exercises the basic state
// transitions, then hand-written sequences cover completion, stall,
// simultaneous events, sticky/clear behaviour, async reset and the trace.
module tb_retire_monitor;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] pc_w;
  logic          retire_w;
  logic          clear;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] retire_cnt;
  logic [AW-1:0] last_pc;
  logic [2:0]    trace_idx;
  logic [AW-1:0] trace_pc;

  int total = 0;
  int bad   = 0;

  retire_monitor #(
    .ADDR_SIZE (AW),
    .END_PC    (32'h0000_0078),
    .WDT_CYCLES(16),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pc_w      (pc_w),
    .retire_w  (retire_w),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt),
    .last_pc   (last_pc),
    .trace_idx (trace_idx),
    .trace_pc  (trace_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ret;
    logic [AW-1:0] pc;
    logic          clr;
    logic          e_busy;
    logic          e_done;
    logic          e_to;
    logic [CW-1:0] e_rc;
    logic [CW-1:0] e_cc;
    logic [AW-1:0] e_lpc;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic eb, input logic ed, input logic et,
                           input logic [CW-1:0] erc, input logic [CW-1:0] ecc,
                           input logic [AW-1:0] elpc);
    check({tag, ".busy"}, 64'(busy), 64'(eb));
    check({tag, ".done"}, 64'(done), 64'(ed));
    check({tag, ".timeout"}, 64'(timeout), 64'(et));
    check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(erc));
    check({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'(ecc));
    check({tag, ".last_pc"}, 64'(last_pc), 64'(elpc));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic ret, input logic [AW-1:0] pc, input logic clr);
    retire_w = ret;
    pc_w     = pc;
    clear    = clr;
    @(posedge clk);
    #1;
    retire_w = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_clear();
    cycle(1'b0, '0, 1'b1);
  endtask

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL sim_guard: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn      = 1'b0;
    pc_w      = '0;
    retire_w  = 1'b0;
    clear     = 1'b0;
    trace_idx = '0;

    //              ret  pc      clr  busy done to   rc  cc  lpc
    vt[0] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h10};
    vt[1] = '{1'b0, 32'h78, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 32'h10};
    vt[2] = '{1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd3, 32'h14};
    vt[3] = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
    vt[4] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
    vt[5] = '{1'b1, 32'h78, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 32'h78};
    vt[6] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 32'h78};
    vt[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
    vt[8] = '{1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h30};
    vt[9] = '{1'b1, 32'h78, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'd2, 32'h78};

    // Reset state.
    #12;
    check_all("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("reset.trace_pc", 64'(trace_pc), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].ret, vt[i].pc, vt[i].clr);
      check_all($sformatf("vec%0d", i), vt[i].e_busy, vt[i].e_done, vt[i].e_to,
                vt[i].e_rc, vt[i].e_cc, vt[i].e_lpc);
    end

    // Normal completion: 31 retires 0x00..0x78, one per cycle.
    do_clear();
    for (int i = 0; i < 31; i++) begin
      cycle(1'b1, AW'(4 * i), 1'b0);
      if (i == 29) check_all("run.pre_end", 1'b1, 1'b0, 1'b0, 32'd30, 32'd30, 32'h74);
    end
    check_all("run.end", 1'b0, 1'b1, 1'b0, 32'd31, 32'd31, 32'h78);

    // Sticky DONE: further retires are ignored.
    for (int i = 0; i < 3; i++) cycle(1'b1, AW'(32'h200 + 4 * i), 1'b0);
    check_all("sticky_done", 1'b0, 1'b1, 1'b0, 32'd31, 32'd31, 32'h78);
    do_clear();
    check_all("clear", 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // END_PC on the bus without retire is ignored.
    cycle(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h78, 1'b0);
    check_all("end_noretire", 1'b1, 1'b0, 1'b0, 32'd1, 32'd6, 32'h0);

    // Stalled pipeline: 16 no-retire cycles times out.
    do_clear();
    cycle(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 32'h4, 1'b0);
    check_all("stall.pre", 1'b1, 1'b0, 1'b0, 32'd1, 32'd16, 32'h0);
    cycle(1'b0, 32'h4, 1'b0);
    check_all("stall.to", 1'b0, 1'b0, 1'b1, 32'd1, 32'd17, 32'h0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 32'h78, 1'b0);
    check_all("sticky_to", 1'b0, 1'b0, 1'b1, 32'd1, 32'd17, 32'h0);

    // END_PC retire on the exact watchdog-expiry cycle: retire wins.
    do_clear();
    cycle(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 32'h4, 1'b0);
    cycle(1'b1, 32'h78, 1'b0);
    check_all("simul", 1'b0, 1'b1, 1'b0, 32'd2, 32'd17, 32'h78);

    // Async reset mid-RUN clears outputs before the next clock edge.
    do_clear();
    cycle(1'b1, 32'h0, 1'b0);
    cycle(1'b1, 32'h4, 1'b0);
    check_all("pre_rst", 1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 32'h4);
    rstn = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b1, 32'h40, 1'b0);
    check_all("post_rst", 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h40);

    // Trace history: 10 retires 0x100..0x124.
    do_clear();
    trace_idx = 3'd0;
    #1;
    check("trace.cleared", 64'(trace_pc), 64'h0);
    for (int i = 0; i < 10; i++) cycle(1'b1, AW'(32'h100 + 4 * i), 1'b0);
    trace_idx = 3'd0;
    #1;
`ifdef RETIRE_TRACE_EN
    check("trace.idx0", 64'(trace_pc), 64'h124);
`else
    check("trace.idx0", 64'(trace_pc), 64'h0);
`endif
    trace_idx = 3'd7;
    #1;
`ifdef RETIRE_TRACE_EN
    check("trace.idx7", 64'(trace_pc), 64'h108);
`else
    check("trace.idx7", 64'(trace_pc), 64'h0);
`endif
    check_all("trace.cnt", 1'b1, 1'b0, 1'b0, 32'd10, 32'd10, 32'h124);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_monitor.md
RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 32, meaning the PC width.
REQ-002 The block SHALL have parameter END_PC, default 32'h00000078, meaning the address of the last program instruction.
REQ-003 The block SHALL have parameter WDT_CYCLES, default 1024, meaning the maximum number of consecutive RUN cycles without a retire before timeout.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning the counter width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port pc_w, input, ADDR_SIZE bits, the PC of the writeback-stage instruction.
REQ-008 The block SHALL have port retire_w, input, 1 bit, high when pc_w retires this cycle.
REQ-009 The block SHALL have port clear, input, 1 bit, a synchronous return to IDLE.
REQ-010 The block SHALL have port busy, output, 1 bit, high when state is RUN.
REQ-011 The block SHALL have port done, output, 1 bit, high when state is DONE.
REQ-012 The block SHALL have port timeout, output, 1 bit, high when state is TIMEOUT.
REQ-013 The block SHALL have port cycle_cnt, output, CNT_W bits, the count of cycles run.
REQ-014 The block SHALL have port retire_cnt, output, CNT_W bits, the count of retired instructions.
REQ-015 The block SHALL have port last_pc, output, ADDR_SIZE bits, the PC of the most recent retire.
REQ-016 The block SHALL have port trace_idx, input, 3 bits, selecting a trace history entry, where 0 is the newest.
REQ-017 The block SHALL have port trace_pc, output, ADDR_SIZE bits, the selected history PC, read combinationally.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, RUN, DONE and TIMEOUT; all outputs other than trace_pc SHALL be registered.
REQ-019 clear SHALL have priority over every other event: next state IDLE, all counters and last_pc zeroed, and trace entries and pointer zeroed.
REQ-020 In IDLE, retire_w=1 SHALL increment retire_cnt, load last_pc, set cycle_cnt to 1 and move to RUN, or move to DONE if pc_w==END_PC.
REQ-021 In RUN, cycle_cnt SHALL increment every cycle, and retire_w=1 SHALL increment retire_cnt and load last_pc.
REQ-022 In RUN, retire_w=1 with pc_w==END_PC SHALL move to DONE; done SHALL assert on the cycle after that edge, with counters including the END_PC retire.
REQ-023 When pc_w==END_PC and retire_w=0, the block SHALL ignore the match.
REQ-024 A watchdog counter SHALL zero on every retire and increment on each RUN cycle without a retire.
REQ-025 When the watchdog reaches WDT_CYCLES-1 and a further no-retire RUN cycle occurs, the block SHALL move to TIMEOUT.
REQ-026 If an END_PC retire and watchdog expiry fall in the same cycle, the retire SHALL win and the block SHALL move to DONE.
REQ-027 DONE and TIMEOUT SHALL be sticky: counters, last_pc and trace SHALL freeze, retire_w SHALL be ignored, and only clear or reset SHALL exit.
REQ-028 cycle_cnt and retire_cnt SHALL saturate at all-ones and not wrap.

Reset
REQ-029 On rstn low, the block SHALL asynchronously enter IDLE.
REQ-030 On rstn low, busy, done and timeout SHALL be 0, and cycle_cnt, retire_cnt, last_pc and the watchdog SHALL be 0.
REQ-031 On rstn low, the trace pointer and trace entries SHALL be 0.
REQ-032 Reset asserted mid-RUN SHALL discard all progress.
REQ-033 After rstn deasserts, the first retire SHALL be treated as an IDLE retire.

Configuration
REQ-034 With RETIRE_TRACE_EN defined, the block SHALL implement an 8-entry ring buffer written with pc_w on each counted retire, whose write pointer wraps from 7 to 0.
REQ-035 With RETIRE_TRACE_EN defined, trace_pc SHALL equal entry[(wptr-1-trace_idx) mod 8], and unwritten entries SHALL read 0.
REQ-036 Without RETIRE_TRACE_EN, the block SHALL contain no trace storage and SHALL tie trace_pc to 0, with trace_idx ignored.

Verification
REQ-037 The bench SHALL cover normal completion: reset, then retire PCs 0x00,0x04,...,0x78 one per cycle (31 retires) -> done=1 one cycle after the 0x78 retire, retire_cnt=31, cycle_cnt=31, last_pc=0x78, busy=0.
REQ-038 The bench SHALL cover a stalled pipeline with WDT_CYCLES=16: retire 0x00, then hold retire_w=0 -> timeout=1 after 16 no-retire cycles, retire_cnt=1, cycle_cnt=17.
REQ-039 The bench SHALL cover a simultaneous event: the END_PC retire on exactly the watchdog expiry cycle -> done=1, timeout=0.
REQ-040 The bench SHALL cover END_PC without retire: pc_w=0x78, retire_w=0 for 5 cycles -> state stays RUN, retire_cnt unchanged.
REQ-041 The bench SHALL cover sticky and clear behaviour: after done, drive 3 more retires -> counters frozen; pulse clear -> IDLE, all outputs 0; assert rstn=0 mid-RUN -> outputs 0 asynchronously, before the next clk edge.
REQ-042 The bench SHALL cover the trace, with RETIRE_TRACE_EN defined: retire 10 PCs 0x100..0x124 -> trace_idx=0 gives 0x124, trace_idx=7 gives 0x108 (wrap verified); without the macro, trace_pc=0.
